// File: rtl/mdu_writeback.sv
// mdu_writeback: iterative 32-bit multiply/divide unit that drives the
// register file write port (BusW, RW, RegWr) for one cycle per operation.
//
// state | meaning
// IDLE  | waiting for Start; operands and Dst captured on accept
// CALC  | one radix-2 step per cycle, 32 steps, counter runs 31 down to 0
// FIX   | sign fixup and result selection; BusW/RW loaded on exit
// DONE  | Done pulse; RegWr asserted when RW != 0
module mdu_writeback (
  input  logic        Clk,
  input  logic        Reset_n,
  input  logic        Start,
  input  logic [1:0]  Op,
  input  logic [31:0] OpA,
  input  logic [31:0] OpB,
  input  logic [4:0]  Dst,
  output logic        Busy,
  output logic        Done,
  output logic [31:0] BusW,
  output logic [4:0]  RW,
  output logic        RegWr
);

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} stateT;

  localparam logic [1:0] OP_MUL   = 2'b00;
  localparam logic [1:0] OP_MULHU = 2'b01;
  localparam logic [1:0] OP_DIV   = 2'b10;
  localparam logic [1:0] OP_REM   = 2'b11;

  stateT       state, stateNext;
  logic [4:0]  cnt;
  logic [1:0]  opReg;
  logic [31:0] operand;   // multiplicand magnitude, or divisor magnitude
  logic [31:0] hi;        // product high word, or partial remainder
  logic [31:0] lo;        // multiplier shifting out / product low word, or dividend -> quotient
  logic        negRes;
  logic        divZero;
  logic [4:0]  dstReg;

  logic        signA, signB;
  logic [31:0] magA, magB;
  logic [32:0] mulSum;
  logic [32:0] divShift, divDiff;
  logic        divGe;
  logic [31:0] fixResult;

  // Operand magnitudes; MULHU treats both operands as unsigned.
  always_comb begin
    signA = OpA[31] & (Op != OP_MULHU);
    signB = OpB[31] & (Op != OP_MULHU);
    magA  = signA ? (~OpA + 32'd1) : OpA;
    magB  = signB ? (~OpB + 32'd1) : OpB;
  end

  // One shift-add step and one restoring-divide step, selected later by opReg.
  always_comb begin
    mulSum   = {1'b0, hi} + (lo[0] ? {1'b0, operand} : 33'd0);
    divShift = {hi, lo[31]};
    divDiff  = divShift - {1'b0, operand};
    divGe    = ~divDiff[32];
  end

  // Result selection and sign fixup applied in FIX.
  always_comb begin
    fixResult = lo;
    case (opReg)
      OP_MUL:   fixResult = negRes ? (~lo + 32'd1) : lo;
      OP_MULHU: fixResult = hi;
      OP_DIV:   fixResult = divZero ? 32'hFFFF_FFFF : (negRes ? (~lo + 32'd1) : lo);
      OP_REM:   fixResult = negRes ? (~hi + 32'd1) : hi;
      default:  fixResult = lo;
    endcase
  end

  // State register.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) state <= IDLE;
    else          state <= stateNext;
  end

  // Next-state logic.
  always_comb begin
    stateNext = state;
    case (state)
      IDLE:    if (Start) stateNext = CALC;
      CALC:    if (cnt == 5'd0) stateNext = FIX;
      FIX:     stateNext = DONE;
      DONE:    stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  // Operand capture, iteration counter and datapath steps.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      cnt     <= 5'd0;
      opReg   <= OP_MUL;
      operand <= 32'd0;
      hi      <= 32'd0;
      lo      <= 32'd0;
      negRes  <= 1'b0;
      divZero <= 1'b0;
      dstReg  <= 5'd0;
    end else begin
      case (state)
        IDLE: begin
          if (Start) begin
            cnt     <= 5'd31;
            opReg   <= Op;
            dstReg  <= Dst;
            hi      <= 32'd0;
            divZero <= (OpB == 32'd0);
            // REM follows the dividend's sign; MUL and DIV use the sign product.
            negRes  <= (Op == OP_REM) ? signA : (signA ^ signB);
            if (Op[1]) begin
              operand <= magB;
              lo      <= magA;
            end else begin
              operand <= magA;
              lo      <= magB;
            end
          end
        end
        CALC: begin
          cnt <= cnt - 5'd1;
          if (opReg[1]) begin
            hi <= divGe ? divDiff[31:0] : divShift[31:0];
            lo <= {lo[30:0], divGe};
          end else begin
            hi <= mulSum[32:1];
            lo <= {mulSum[0], lo[31:1]};
          end
        end
        default: ;
      endcase
    end
  end

  // Write-port registers: loaded leaving FIX so they are settled for all of DONE.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      BusW <= 32'd0;
      RW   <= 5'd0;
    end else if (state == FIX) begin
      BusW <= fixResult;
      RW   <= dstReg;
    end
  end

  // Status outputs decoded from state; register 0 is never written.
  always_comb begin
    Busy  = (state != IDLE);
    Done  = (state == DONE);
    RegWr = (state == DONE) && (RW != 5'd0);
  end

endmodule

// File: doc/mdu_writeback.md
# mdu_writeback

Iterative 32-bit multiply/divide unit that sits directly upstream of the 32x32 register file. It consumes the two register read buses (BusA/BusB values) and a destination index. After a fixed multi-cycle computation it drives the register file's write port (BusW, RW, RegWr) for exactly one cycle.

## Interface
- No parameters; datapath fixed at 32 bits, register index at 5 bits.
- Clk  input  1  system clock; all state updates on posedge.
- Reset_n  input  1  asynchronous, active-low reset.
- Start  input  1  request; sampled on posedge only while idle (Busy=0).
- Op  input  2  00 MUL (low 32 of signed product), 01 MULHU (high 32 of unsigned product), 10 DIV (signed quotient), 11 REM (signed remainder).
- OpA  input  32  operand A (from BusA): multiplicand/dividend; captured with Start.
- OpB  input  32  operand B (from BusB): multiplier/divisor; captured with Start.
- Dst  input  5  destination register index; captured with Start.
- Busy  output  1  high from the posedge after Start is accepted until the unit returns to IDLE.
- Done  output  1  one-cycle completion pulse.
- BusW  output  32  result to the register file write bus; holds the last result.
- RW  output  5  destination index to the register file; holds the last Dst.
- RegWr  output  1  write enable to the register file; high only in the Done cycle, and only when RW != 0.

## Operation
- FSM states: IDLE, CALC, FIX, DONE.
  - IDLE -> CALC on Start=1.
  - CALC -> FIX when the iteration counter reaches 0.
  - FIX -> DONE unconditionally.
  - DONE -> IDLE unconditionally.
- On accept, capture OpA, OpB, Dst and Op.
  - For signed ops (MUL, DIV, REM), convert operands to magnitudes and record the result sign.
  - Load the 5-bit counter with 31.
- CALC performs one radix-2 step per cycle, 32 cycles total.
  - Multiply: shift-add into a 64-bit accumulator.
  - Divide: restoring divide, one quotient bit per cycle; 32-bit remainder, 32-bit quotient.
- FIX applies the sign and selects the result half.
  - MUL: low word; two's-complement negate if the sign differs.
  - MULHU: high word, unsigned, no fixup.
  - DIV: quotient negated if sign(OpA) != sign(OpB).
  - REM: remainder takes the sign of OpA.
- Divide by zero (OpB=0): DIV result 0xFFFFFFFF, REM result = OpA. No exception; the full latency still applies.
- Signed overflow (OpA=0x80000000, OpB=0xFFFFFFFF): DIV result 0x80000000, REM result 0.
- Dst=0: the computation runs and Done pulses, but RegWr stays 0, so register 0 is never written.
- Start while Busy=1 is ignored; there is no queueing. Start asserted in the DONE cycle is also ignored.
- Operand inputs may change freely after the accept edge.

## Timing
- Reset (Reset_n=0, asynchronous, any state, including mid-CALC):
  - FSM to IDLE, counter 0.
  - Busy=0, Done=0, RegWr=0, BusW=0, RW=0.
  - The in-flight operation is discarded and nothing is written.
- Take the accept edge as posedge N.
  - Busy=1 after edge N.
  - CALC iterations occur on edges N+1..N+32.
  - FIX is the cycle after edge N+32.
  - DONE is the cycle after edge N+33: Done=1, RegWr=(RW!=0), BusW/RW valid.
  - After edge N+34: IDLE, Busy=0, Done=0, RegWr=0.
- Latency is fixed at 33 cycles from the accept edge to Done, independent of operand values.
- The earliest next accept is edge N+35 (Start must be high in the first IDLE cycle).
- BusW and RW are registered and stable for the whole DONE cycle, so the register file's negedge write in that cycle sees settled data.
- BusW and RW hold their values until the next FIX.

## Test plan
- Reset check: drive Reset_n=0 mid-CALC, then release. Required: all outputs 0 and RegWr never pulses; a new Start after release completes normally.
- MUL: OpA=0xFFFFFFFD (-3), OpB=7, Dst=5. Required: Done exactly 33 cycles after accept, BusW=0xFFFFFFEB, RW=5, RegWr=1 for one cycle.
- MULHU: OpA=OpB=0xFFFFFFFF. Required: BusW=0xFFFFFFFE.
- DIV/REM: OpA=0xFFFFFFF9 (-7), OpB=2. Required: DIV gives 0xFFFFFFFD and REM gives 0xFFFFFFFF.
- Corner cases:
  - DIV by 0 with OpA=0x1234 gives BusW=0xFFFFFFFF; REM by 0 gives 0x1234.
  - DIV 0x80000000 / 0xFFFFFFFF gives 0x80000000.
  - Dst=0 gives Done=1 with RegWr=0.
- Back-to-back: hold Start=1 continuously. Required:
  - Second accept occurs exactly at edge N+35.
  - Start during Busy has no effect.
  - Captured operands are unaffected by OpA/OpB changes mid-operation.
